// File: rtl/sm3_pkg.sv
// SM3 message expansion shared types, constants and the P1 permutation.
package sm3_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SM3_ROUNDS = 64;
  localparam int SM3_WIN    = 16;

  localparam int unsigned ROT_A = 15;
  localparam int unsigned ROT_B = 7;
  localparam int unsigned ROT_C = 23;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic word_t p1(input word_t x);
    return x ^ rotl(x, ROT_A) ^ rotl(x, ROT_C);
  endfunction

endpackage

// File: rtl/sm3_expnd_word.sv
// SM3 next-word generator: W[j+16] from five words of the sliding window.
module sm3_expnd_word
  import sm3_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w3,
  input  logic [31:0] w7,
  input  logic [31:0] w10,
  input  logic [31:0] w13,
  output logic [31:0] w16
);

  word_t pre;

  assign pre = w0 ^ w7 ^ rotl(w13, ROT_A);
  assign w16 = p1(pre) ^ rotl(w3, ROT_B) ^ w10;

endmodule

// File: rtl/sm3_msg_expand.sv
// SM3 message expansion: 512-bit block in, 64 (W_j, W'_j) pairs out.
// Define SM3_EXPND_OREG_EN to register every output.
module sm3_msg_expand
  import sm3_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_j,
  output logic [31:0]  wp_j,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         busy
);

  state_t     state;
  state_t     state_nx;
  word_t      win [SM3_WIN];
  logic [5:0] j;
  word_t      w_new;
  logic       accept;
  logic       src_valid;
  logic       src_fire;
  logic       src_end;
  logic       fin;

  assign blk_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign accept    = blk_valid && blk_ready;
  assign src_end   = (j == 6'(SM3_ROUNDS - 1));

  sm3_expnd_word u_word (
    .w0  (win[0]),
    .w3  (win[3]),
    .w7  (win[7]),
    .w10 (win[10]),
    .w13 (win[13]),
    .w16 (w_new)
  );

`ifdef SM3_EXPND_OREG_EN
  logic src_done;
  logic adv;

  // The stage refills whenever it is empty or being drained.
  assign src_valid = busy && !src_done;
  assign adv       = !w_valid || w_ready;
  assign src_fire  = src_valid && adv;
  assign fin       = w_valid && w_ready && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_done <= 1'b0;
      w_valid  <= 1'b0;
      w_j      <= '0;
      wp_j     <= '0;
      w_idx    <= '0;
      w_last   <= 1'b0;
    end else begin
      if (accept)
        src_done <= 1'b0;
      else if (src_fire && src_end)
        src_done <= 1'b1;
      if (adv) begin
        w_valid <= src_valid;
        w_last  <= src_valid && src_end;
        if (src_valid) begin
          w_j   <= win[0];
          wp_j  <= win[0] ^ win[4];
          w_idx <= j;
        end
      end
    end
  end
`else
  assign src_valid = busy;
  assign src_fire  = src_valid && w_ready;
  assign fin       = src_fire && src_end;

  assign w_valid = src_valid;
  assign w_j     = win[0];
  assign wp_j    = win[0] ^ win[4];
  assign w_idx   = j;
  assign w_last  = src_valid && src_end;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      accept:  state_nx = RUN;
      fin:     state_nx = IDLE;
      default: state_nx = state;
    endcase
  end

  // Window keeps sliding past j=48 so W64..W67 exist for wp_j.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SM3_WIN; i++)
        win[i] <= '0;
      j <= '0;
    end else if (accept) begin
      for (int i = 0; i < SM3_WIN; i++)
        win[i] <= blk_data[511 - 32*i -: 32];
      j <= '0;
    end else if (src_fire) begin
      for (int i = 0; i < SM3_WIN - 1; i++)
        win[i] <= win[i+1];
      win[SM3_WIN-1] <= w_new;
      j <= j + 6'd1;
    end
  end

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Directed bench for sm3_msg_expand (plain or SM3_EXPND_OREG_EN build).
module tb_sm3_msg_expand;

`ifdef SM3_EXPND_OREG_EN
  localparam int LAT  = 1;
  localparam int LAST = 65;
`else
  localparam int LAT  = 0;
  localparam int LAST = 64;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic [31:0]  w_j;
  logic [31:0]  wp_j;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;

  int nchk = 0;
  int nfail = 0;

  logic [31:0]  exp_w [68];
  logic [31:0]  got_w [64];
  logic [31:0]  got_wp0;
  logic [511:0] abc_blk;
  logic [511:0] b_blk;
  int           first_e;
  int           last_e;

  always #5 clk = ~clk;

  sm3_msg_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_j       (w_j),
    .wp_j      (wp_j),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .busy      (busy)
  );

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  task automatic build_model(input logic [511:0] d);
    logic [31:0] x;
    for (int i = 0; i < 16; i++)
      exp_w[i] = d[511 - 32*i -: 32];
    for (int i = 16; i < 68; i++) begin
      x = exp_w[i-16] ^ exp_w[i-9] ^ rl(exp_w[i-3], 15);
      exp_w[i] = x ^ rl(x, 15) ^ rl(x, 23) ^ rl(exp_w[i-13], 7) ^ exp_w[i-6];
    end
  endtask

  task automatic load_block(input logic [511:0] d, input bit keep);
    int k;
    k = 0;
    blk_data  = d;
    blk_valid = 1'b1;
    while (!blk_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    nchk++;
    if (!blk_ready) begin
      nfail++;
      $display("FAIL load_wait: blk_ready=%b required 1", blk_ready);
    end
    @(posedge clk);
    @(negedge clk);
    if (!keep) blk_valid = 1'b0;
  endtask

  // Called at the negedge right after the accepting edge.
  task automatic drain(input bit rnd);
    int e, cnt;
    bit stall;
    logic [31:0] s_w, s_wp;
    logic [5:0] s_idx;
    logic s_last;
    e = 0; cnt = 0; stall = 0;
    first_e = -1; last_e = -1;
    s_w = '0; s_wp = '0; s_idx = '0; s_last = 1'b0;
    while (cnt < 64 && e < 3000) begin
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall) begin
        nchk++;
        if (w_valid !== 1'b1 || w_j !== s_w || wp_j !== s_wp ||
            w_idx !== s_idx || w_last !== s_last) begin
          nfail++;
          $display("FAIL stall_hold: v=%b w=%h wp=%h idx=%0d last=%b required v=1 w=%h wp=%h idx=%0d last=%b",
                   w_valid, w_j, wp_j, w_idx, w_last, s_w, s_wp, s_idx, s_last);
        end
      end
      if (w_valid && first_e < 0) first_e = e;
      if (w_valid && w_ready) begin
        nchk++;
        if (w_j !== exp_w[cnt]) begin
          nfail++;
          $display("FAIL w_j[%0d]: got %h required %h", cnt, w_j, exp_w[cnt]);
        end
        nchk++;
        if (wp_j !== (exp_w[cnt] ^ exp_w[cnt+4])) begin
          nfail++;
          $display("FAIL wp_j[%0d]: got %h required %h", cnt, wp_j, exp_w[cnt] ^ exp_w[cnt+4]);
        end
        nchk++;
        if (w_idx !== 6'(cnt)) begin
          nfail++;
          $display("FAIL w_idx: got %0d required %0d", w_idx, cnt);
        end
        nchk++;
        if (w_last !== (cnt == 63)) begin
          nfail++;
          $display("FAIL w_last[%0d]: got %b required %b", cnt, w_last, cnt == 63);
        end
        nchk++;
        if (blk_ready !== 1'b0 || busy !== 1'b1) begin
          nfail++;
          $display("FAIL run_flags[%0d]: ready=%b busy=%b required 0/1", cnt, blk_ready, busy);
        end
        got_w[cnt] = w_j;
        if (cnt == 0) got_wp0 = wp_j;
        if (cnt == 63) last_e = e + 1;
        cnt++;
      end
      stall = w_valid && !w_ready;
      s_w = w_j; s_wp = wp_j; s_idx = w_idx; s_last = w_last;
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    nchk++;
    if (cnt != 64) begin
      nfail++;
      $display("FAIL hs_count: got %0d required 64", cnt);
    end
    nchk++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || blk_ready !== 1'b1) begin
      nfail++;
      $display("FAIL post_block: v=%b busy=%b ready=%b required 0/0/1", w_valid, busy, blk_ready);
    end
    nchk++;
    if (first_e != LAT) begin
      nfail++;
      $display("FAIL first_valid: got %0d required %0d", first_e, LAT);
    end
  endtask

  task automatic check_idle(input string tag);
    nchk++;
    if (blk_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0 || w_last !== 1'b0 ||
        w_j !== 32'h0 || wp_j !== 32'h0 || w_idx !== 6'h0) begin
      nfail++;
      $display("FAIL %s: rdy=%b v=%b busy=%b last=%b w=%h wp=%h idx=%0d required 1/0/0/0/0/0/0",
               tag, blk_ready, w_valid, busy, w_last, w_j, wp_j, w_idx);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_idle("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("after_release");
  endtask

  task automatic test_abc();
    build_model(abc_blk);
    load_block(abc_blk, 1'b0);
    drain(1'b0);
    nchk++;
    if (last_e != LAST) begin
      nfail++;
      $display("FAIL last_edge: got %0d required %0d", last_e, LAST);
    end
    nchk++;
    if (got_w[16] !== 32'h9092e200 || got_w[17] !== 32'h00000000 ||
        got_w[18] !== 32'h000c0606 || got_w[19] !== 32'h719c70ed) begin
      nfail++;
      $display("FAIL abc_w16_19: got %h %h %h %h required 9092e200 00000000 000c0606 719c70ed",
               got_w[16], got_w[17], got_w[18], got_w[19]);
    end
    nchk++;
    if (got_wp0 !== 32'h61626380) begin
      nfail++;
      $display("FAIL abc_wp0: got %h required 61626380", got_wp0);
    end
  endtask

  task automatic test_stall();
    build_model(abc_blk);
    load_block(abc_blk, 1'b0);
    drain(1'b1);
    nchk++;
    if (got_w[16] !== 32'h9092e200 || got_w[19] !== 32'h719c70ed) begin
      nfail++;
      $display("FAIL stall_words: got %h %h required 9092e200 719c70ed", got_w[16], got_w[19]);
    end
  endtask

  task automatic test_back_to_back();
    build_model(abc_blk);
    load_block(abc_blk, 1'b1);
    blk_data = b_blk;
    drain(1'b0);
    @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0;
    nchk++;
    if (busy !== 1'b1 || blk_ready !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_accept: busy=%b ready=%b required 1/0", busy, blk_ready);
    end
    build_model(b_blk);
    drain(1'b0);
  endtask

  task automatic test_reset_abort();
    int k;
    build_model(abc_blk);
    load_block(abc_blk, 1'b0);
    w_ready = 1'b1;
    k = 0;
    #1;
    while (!(w_valid && w_idx == 6'd30) && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    nchk++;
    if (!(w_valid && w_idx == 6'd30)) begin
      nfail++;
      $display("FAIL reach_j30: v=%b idx=%0d required 1/30", w_valid, w_idx);
    end
    rst_n = 1'b0;
    #1;
    check_idle("abort_reset");
    @(posedge clk);
    @(negedge clk);
    check_idle("abort_hold");
    rst_n = 1'b1;
    load_block(abc_blk, 1'b0);
    drain(1'b0);
    nchk++;
    if (got_w[0] !== 32'h61626380) begin
      nfail++;
      $display("FAIL restart_w0: got %h required 61626380", got_w[0]);
    end
  endtask

  initial begin
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++)
      b_blk[511 - 32*i -: 32] = 32'h9e3779b9 * (i + 1) ^ 32'h0f0f1234;
    test_reset();
    test_abc();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/sm3_msg_expand.md
SM3_MSG_EXPAND -- requirements
Module: sm3_msg_expand

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and act as the single clock; all state is updated on its rising edge.
REQ-002 The port rst_n SHALL be an input, 1 bit wide, and act as the asynchronous, active-low reset.
REQ-003 The port blk_valid SHALL be an input, 1 bit wide; when high, a 512-bit message block is offered.
REQ-004 The port blk_ready SHALL be an output, 1 bit wide; when high, the block can be accepted.
REQ-005 The port blk_data SHALL be an input, 512 bits wide, carrying the block; word W0 is in [511:480] and W15 is in [31:0].
REQ-006 The port w_valid SHALL be an output, 1 bit wide; when high, the round operands are valid.
REQ-007 The port w_ready SHALL be an input, 1 bit wide; when high, the compression side takes the operands.
REQ-008 The port w_j SHALL be an output, 32 bits wide, carrying W_j.
REQ-009 The port wp_j SHALL be an output, 32 bits wide, carrying W'_j = W_j ^ W_{j+4}.
REQ-010 The port w_idx SHALL be an output, 6 bits wide, carrying the round index j (0..63).
REQ-011 The port w_last SHALL be an output, 1 bit wide, high when j = 63.
REQ-012 The port busy SHALL be an output, 1 bit wide, high while a block is being expanded.

Function
REQ-013 The block SHALL accept a block when blk_valid and blk_ready are both high at a rising clk edge.
REQ-014 The FSM SHALL have two states, IDLE and RUN.
- IDLE to RUN on block accept.
- RUN to IDLE on the output handshake with j = 63.
REQ-015 blk_ready SHALL equal (state == IDLE), and busy SHALL equal (state == RUN).
REQ-016 On accept, the block SHALL load a 16-word window win[0..15] = W0..W15 and set j = 0.
REQ-017 In RUN, the outputs SHALL be driven from the window as follows:
- w_j = win[0]
- wp_j = win[0] ^ win[4]
- w_idx = j
REQ-018 On each output handshake (w_valid & w_ready), the window SHALL shift down one word, win[15] SHALL take W_{j+16}, and j SHALL increment.
- W_{j+16} = P1(win[0] ^ win[7] ^ rotl(win[13],15)) ^ rotl(win[3],7) ^ win[10]
- P1(x) = x ^ rotl(x,15) ^ rotl(x,23)
REQ-019 The block SHALL produce exactly 64 handshakes per block; words W64..W67 are generated internally only to feed wp_j.
REQ-020 While w_valid is high and w_ready is low, w_j, wp_j, w_idx and w_last SHALL hold stable.
REQ-021 Sustained throughput SHALL be one word per cycle while w_ready is held high.
REQ-022 If blk_valid is high in the same cycle as the final handshake, the block SHALL NOT be accepted that cycle; it is accepted on the next cycle, when blk_ready is high.
REQ-023 Without the macro in REQ-027, w_valid SHALL rise in the cycle after accept, and the last handshake leaves 64 cycles after accept when w_ready is held high.
REQ-024 All arithmetic SHALL be 32-bit XOR and rotation only; the block contains no adders.

Reset
REQ-025 While rst_n is low, the block SHALL be in state IDLE with blk_ready = 1 and w_valid = busy = w_last = 0, and w_j, wp_j, w_idx and the window all 0.
REQ-026 An rst_n assertion during RUN SHALL abort the block immediately with no further output handshakes; the block is accepted afresh after release.

Configuration
REQ-027 When SM3_EXPND_OREG_EN is defined, a registered output stage SHALL be inserted:
- all outputs come directly from flops;
- w_valid rises 2 cycles after accept;
- the stage advances when it is empty or w_ready is high;
- throughput stays 1 word per cycle;
- REQ-020 and REQ-022 still hold.
REQ-028 When SM3_EXPND_OREG_EN is undefined, the outputs SHALL be combinational from the window and the FSM, per REQ-023.

Structure
REQ-029 The shared package sm3_pkg SHALL hold:
- the 32-bit word typedef;
- the constants SM3_ROUNDS = 64 and SM3_WIN = 16;
- the rotation amounts 15, 7 and 23;
- the P1 function.
REQ-030 The next-word generator SHALL be the combinational sub-module sm3_expnd_word, with five 32-bit window inputs and one 32-bit output.

Verification
REQ-031 The bench SHALL cover the "abc" padded block: W0 = 61626380, W1..W14 = 0, W15 = 00000018, with w_ready = 1.
- Expected words: w_j at j = 16..19 is 9092e200, 00000000, 000c0606, 719c70ed.
- Expected wp_j at j = 0 is 61626380.
- Expected handshake count: 64, with w_last only at j = 63.
REQ-032 The bench SHALL toggle w_ready randomly for the "abc" block; the word sequence must be identical to REQ-031 and the outputs must hold during stalls.
REQ-033 The bench SHALL hold blk_valid high continuously across two blocks; the second block must be accepted in the cycle after the first block's j = 63 handshake, with no overlap.
REQ-034 The bench SHALL drop rst_n at j = 30 and then reload the "abc" block; after reset all outputs must be at their reset values, and the restart must begin at j = 0 with W0 = 61626380.
REQ-035 The bench SHALL rerun REQ-031 with SM3_EXPND_OREG_EN defined; the words must be identical, and the first w_valid must come 2 cycles after accept.
